// File: rtl/mips32_pkg.sv
// mips32_pkg: shared widths and responder state encoding for the MIPS32 memory responder.
package mips32_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/mips32_mem_array.sv
// mips32_mem_array: synchronous single-port word array with byte-enabled writes.
module mips32_mem_array
    import mips32_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/mips32_mem_responder.sv
// mips32_mem_responder: valid/ready data-memory slave with programmable wait states
// between request acceptance and a held response.
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [WORD_W-1:0] h_wdata;
    logic [BE_W-1:0]   h_be;
    logic              rd_ok;
    logic [WORD_W-1:0] arr_rdata;
    logic              hs, go_resp, in_range;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [WORD_W-1:0] a_wdata;
    logic [BE_W-1:0]   a_be;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    assign hs        = req_valid && state == IDLE;

    // With zero wait states the array is accessed on the acceptance edge itself,
    // before the holding registers are loaded, so take the live request then.
    assign a_we     = (state == IDLE) ? req_we    : h_we;
    assign a_addr   = (state == IDLE) ? req_addr  : h_addr;
    assign a_wdata  = (state == IDLE) ? req_wdata : h_wdata;
    assign a_be     = (state == IDLE) ? req_be    : h_be;
    assign in_range = 32'(a_addr) < 32'(DEPTH);
    assign go_resp  = state != RESP && state_nx == RESP;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            h_we    <= 1'b0;
            h_addr  <= '0;
            h_wdata <= '0;
            h_be    <= '0;
            rsp_err <= 1'b0;
            rd_ok   <= 1'b0;
        end else begin
            state <= state_nx;
            if (hs) begin
                h_we    <= req_we;
                h_addr  <= req_addr;
                h_wdata <= req_wdata;
                h_be    <= req_be;
                cnt     <= 4'(WAIT_CYCLES - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (go_resp) begin
                rsp_err <= !in_range;
                rd_ok   <= !a_we && in_range;
            end
        end
    end

    // Array read data only changes on an accepted in-range load, so masking it
    // with rd_ok yields a held response word that is zero for stores and errors.
    assign rsp_rdata = rd_ok ? arr_rdata : '0;

    mips32_mem_array #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .en    (go_resp && in_range),
        .we    (a_we),
        .be    (a_be),
        .addr  (a_addr),
        .wdata (a_wdata),
        .rdata (arr_rdata)
    );
endmodule

// File: tb/tb_mips32_mem_responder.sv
// tb_mips32_mem_responder: directed checks of a two-wait-state, DEPTH=1000 responder
// alongside a zero-wait build driven by the same request stream.
module tb_mips32_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        req_ready0, rsp_valid0, rsp_err0, busy0;
    logic [31:0] rsp_rdata0;
    int          total = 0, bad = 0;
    logic [31:0] rd;
    logic        err;
    int          lat, lat0;

    always #5 clk = ~clk;

    mips32_mem_responder #(.ADDR_W(10), .DEPTH(1000), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    mips32_mem_responder #(.ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One request; the response is held for `hold` extra cycles before acceptance.
    task automatic xact(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rdo, output logic erro, output int lato, output int lat0o);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lato = 0; lat0o = 0;
        while (lato < 40) begin
            @(negedge clk);
            lato++;
            if (lat0o == 0 && rsp_valid0) lat0o = lato;
            if (rsp_valid) break;
        end
        check("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
        rdo = rsp_rdata; erro = rsp_err;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, rdo);
            check("hold_err", {31'b0, rsp_err}, {31'b0, erro});
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("req_ready_after", {31'b0, req_ready}, 32'd1);
        check("rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'b0, rsp_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'b0, busy}, 32'd0);

        xact(1'b1, 10'd120, 32'd85, 4'hF, 0, rd, err, lat, lat0);
        check("st120_rdata", rd, 32'd0);
        check("st120_err", {31'b0, err}, 32'd0);
        xact(1'b1, 10'd5, 32'h11223344, 4'hF, 0, rd, err, lat, lat0);
        xact(1'b1, 10'd3, 32'h5555, 4'hF, 0, rd, err, lat, lat0);

        xact(1'b0, 10'd120, 32'd0, 4'h0, 0, rd, err, lat, lat0);
        check("ld120_lat", lat, 3);
        check("ld120_rdata", rd, 32'd85);
        check("ld120_err", {31'b0, err}, 32'd0);
        check("w0_lat", lat0, 1);
        check("w0_rdata", rsp_rdata0, 32'd85);

        xact(1'b1, 10'd121, 32'd130, 4'hF, 0, rd, err, lat, lat0);
        check("st121_rdata", rd, 32'd0);
        xact(1'b0, 10'd121, 32'd0, 4'h0, 0, rd, err, lat, lat0);
        check("ld121_rdata", rd, 32'd130);
        check("w0_ld121", rsp_rdata0, 32'd130);
        xact(1'b0, 10'd120, 32'd0, 4'h0, 0, rd, err, lat, lat0);
        check("ld120_again", rd, 32'd85);

        xact(1'b1, 10'd5, 32'hAABBCCDD, 4'b0101, 0, rd, err, lat, lat0);
        xact(1'b0, 10'd5, 32'd0, 4'h0, 0, rd, err, lat, lat0);
        check("ld5_masked", rd, 32'h11BB33DD);
        xact(1'b1, 10'd5, 32'hFFFFFFFF, 4'h0, 0, rd, err, lat, lat0);
        check("st5_be0_err", {31'b0, err}, 32'd0);
        xact(1'b0, 10'd5, 32'd0, 4'h0, 0, rd, err, lat, lat0);
        check("ld5_be0", rd, 32'h11BB33DD);

        xact(1'b0, 10'd120, 32'd0, 4'h0, 5, rd, err, lat, lat0);
        check("hold_ld_rdata", rd, 32'd85);
        check("rdata_retained", rsp_rdata, 32'd85);

        xact(1'b0, 10'd1000, 32'd0, 4'h0, 0, rd, err, lat, lat0);
        check("ld1000_err", {31'b0, err}, 32'd1);
        check("ld1000_rdata", rd, 32'd0);
        check("w0_ld1000_err", {31'b0, rsp_err0}, 32'd0);
        xact(1'b1, 10'd1001, 32'hDEADBEEF, 4'hF, 0, rd, err, lat, lat0);
        check("st1001_err", {31'b0, err}, 32'd1);
        check("st1001_rdata", rd, 32'd0);
        xact(1'b0, 10'd121, 32'd0, 4'h0, 0, rd, err, lat, lat0);
        check("ld121_after_err", rd, 32'd130);
        check("err_cleared", {31'b0, err}, 32'd0);
        xact(1'b0, 10'd120, 32'd0, 4'h0, 0, rd, err, lat, lat0);
        check("ld120_after_err", rd, 32'd85);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd3; req_wdata = 32'd7; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("wait_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready", {31'b0, req_ready}, 32'd1);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("arst_rdata", rsp_rdata, 32'd0);
        check("arst_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_stay_idle", {31'b0, busy}, 32'd0);
        xact(1'b0, 10'd3, 32'd0, 4'h0, 0, rd, err, lat, lat0);
        check("ld3_unchanged", rd, 32'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
